// File: rtl/sub_shift_rows.sv
// sub_shift_rows: iterative AES-128 SubBytes + ShiftRows stage.
//
// Accepts a 128-bit state on a start pulse, substitutes one column (four bytes)
// per cycle through combinational S-boxes and scatters each result directly to
// its ShiftRows position. The finished word is registered on state_out with a
// one-cycle done pulse. This is the row-shifted vector that mixColumns consumes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request, accepted only in IDLE or DONE
//   state_in   128-bit input state, sampled on the accepting edge
//   busy       high while columns are being substituted
//   done       one-cycle pulse when state_out is updated
//   state_out  registered SubBytes+ShiftRows result, held until next completion
//
// Byte n of a 128-bit word is bits [127-8n -: 8]; row = n mod 4, col = n div 4.

module sub_shift_rows (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] work_in_q, work_in_d;
  logic [127:0] work_out_q, work_out_d;
  logic [127:0] state_out_q, state_out_d;
  logic [1:0]   col_q, col_d;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as field inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] in_byte  [16];
  logic [7:0] out_byte [16];
  logic [1:0] row;
  logic [1:0] out_col;

  always_comb begin
    state_d     = state_q;
    work_in_d   = work_in_q;
    work_out_d  = work_out_q;
    state_out_d = state_out_q;
    col_d       = col_q;
    row         = 2'd0;
    out_col     = 2'd0;

    for (int n = 0; n < 16; n++) begin
      in_byte[n]  = work_in_q[127 - 8*n -: 8];
      out_byte[n] = work_out_q[127 - 8*n -: 8];
    end

    // Input byte (r, col) lands at output (r, col - r), with 2-bit wrap.
    for (int r = 0; r < 4; r++) begin
      row     = 2'(r);
      out_col = col_q - row;
      out_byte[{out_col, row}] = sbox(in_byte[{col_q, row}]);
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          work_in_d = state_in;
          col_d     = 2'd0;
          state_d   = StSub;
        end else begin
          state_d   = StIdle;
        end
      end
      StSub: begin
        for (int n = 0; n < 16; n++) begin
          work_out_d[127 - 8*n -: 8] = out_byte[n];
        end
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          // Include this cycle's column in the published result.
          state_out_d = work_out_d;
          state_d     = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      work_in_q   <= 128'h0;
      work_out_q  <= 128'h0;
      state_out_q <= 128'h0;
      col_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      work_in_q   <= work_in_d;
      work_out_q  <= work_out_d;
      state_out_q <= state_out_d;
      col_q       <= col_d;
    end
  end

  assign busy      = (state_q == StSub);
  assign done      = (state_q == StDone);
  assign state_out = state_out_q;

endmodule

// File: doc/sub_shift_rows.md
# sub_shift_rows

Iterative AES-128 SubBytes + ShiftRows stage sitting directly upstream of the combinational `mixColumns` block in the encryption round datapath. It accepts a 128-bit state on a start pulse, substitutes its 16 bytes through the FIPS-197 S-box four bytes per cycle, and writes each byte straight to its ShiftRows position. It presents the result as a registered 128-bit word with a one-cycle done pulse, so `state_out` is exactly the "s_row" vector `mixColumns` consumes.

## Interface
- No parameters. Fixed at AES-128: 128-bit state, 4 S-box lookups per cycle.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled on rising edge, accepted only in IDLE or DONE.
- `state_in`  input  128  input state; sampled only on the accepting edge.
- `busy`  output  1  high while in SUB.
- `done`  output  1  one-cycle pulse; `state_out` is valid from this cycle on.
- `state_out`  output  128  registered SubBytes+ShiftRows result; holds until the next completion.

## Operation
- Byte mapping (FIPS-197): byte n = bits [127-8n -: 8]; row r = n mod 4, column c = n div 4.
- ShiftRows: out(r,c) = S(in(r,(c+r) mod 4)). Equivalently, input byte (r,c) lands at output (r,(c-r) mod 4).
- Registers:
  - `work_in`: 128-bit latched input.
  - `work_out`: 128-bit result accumulator.
  - `col`: 2-bit column counter.
  - FSM state: IDLE, SUB, DONE.
- IDLE:
  - `start`=1 → latch `state_in` into `work_in`, set `col`=0, go to SUB.
  - Otherwise stay in IDLE.
- SUB, each cycle:
  - Pass input column `col` (4 bytes) through 4 combinational S-box lookups.
  - Write the 4 results into `work_out` at their shifted positions.
  - Increment `col`, which wraps 3→0.
  - When `col`==3: load `state_out` with the final `work_out`, including this cycle's 4 bytes, then go to DONE.
- DONE (exactly one cycle; `done`=1):
  - `start`=1 → latch a new `state_in`, `col`=0, go to SUB. This gives back-to-back operation.
  - Otherwise go to IDLE.
- `start` while in SUB is ignored, with no queuing. `work_in` is not modified in SUB.
- S-box: standard 256-entry FIPS-197 table. It may be built as a case ROM or as composite-field inverse + affine logic. Either way it is purely combinational, with no extra pipeline stage.
- No arithmetic beyond the 2-bit counter wrap. All byte moves are fixed-index muxing keyed on `col`.

## Timing
- Reset values, applied asynchronously while `rst`=1:
  - FSM = IDLE, `busy`=0, `done`=0, `col`=0.
  - `state_out`, `work_in`, `work_out` = 128'h0.
- Accepting edge k → SUB. Edges k+1..k+4 process columns 0..3.
- `state_out` and `done` update at edge k+4. Latency is 4 cycles from the accepting edge to `done` high.
- `busy` is high for the 4 cycles between edges k and k+4, and low in the DONE cycle.
- Sustained throughput: one state per 5 cycles, with `start` held or re-pulsed in DONE.
- `rst` asserted mid-SUB aborts immediately. Outputs go to their reset values and no `done` is issued. The first `start` after release is processed normally.
- `state_out` holds its value in IDLE and SUB, including while a following operation is in progress. It changes only at completion edges or reset.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `busy`=0, `done`=0, `state_out`=0 before the next edge. Release, pulse `start` with 00102030405060708090a0b0c0d0e0f0 → after 4 cycles `done`=1, `state_out`=6353e08c0960e104cd70b751bacad0e7.
- Known vector with downstream check: `state_in`=193de3bea0f4e22b9ac68d2ae9f84808 → `state_out`=d4bf5d30e0b452aeb84111f11e2798e5. Feed it to `mixColumns` → 046681e5e0cb199a48f8d37a2806264c.
- Corners: all-zero input → 63636363…63 (16 bytes). All-ones input → 16161616…16.
- Back-to-back: assert `start` in the DONE cycle with the second vector → second `done` exactly 5 cycles after the first. The first result is held on `state_out` until then.
- Ignored start and mid-operation reset:
  - Pulse `start` with a different `state_in` during SUB → the result still matches the first vector and `done` fires once.
  - Assert `rst` during column 2 → no `done` pulse and `state_out`=0.
